// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit ALU and the double-word sequencer that drives it.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_ADC = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_SBC = 4'h3;

  typedef enum logic [1:0] {
    DW_ADD = 2'b00,
    DW_SUB = 2'b01,
    DW_CMP = 2'b10,
    DW_RSV = 2'b11
  } dw_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10,
    ST_DONE = 2'b11
  } dw_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add/adc/sub/sbc with ARM-style carry (subtract C=1 means no borrow).
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  input  logic        cin,
  output logic [31:0] y,
  output logic        cout,
  output logic        v
);

  logic [31:0] b_eff;
  logic        c_eff;
  logic [32:0] sum;

  always_comb begin
    b_eff = b;
    c_eff = 1'b0;
    case (op)
      ALU_ADD: begin b_eff = b;  c_eff = 1'b0; end
      ALU_ADC: begin b_eff = b;  c_eff = cin;  end
      ALU_SUB: begin b_eff = ~b; c_eff = 1'b1; end
      ALU_SBC: begin b_eff = ~b; c_eff = cin;  end
      default: begin b_eff = b;  c_eff = 1'b0; end
    endcase
    // Subtraction is A + ~B + carry, so the carry-out is the inverted borrow.
    sum  = {1'b0, a} + {1'b0, b_eff} + {32'd0, c_eff};
    y    = sum[31:0];
    cout = sum[32];
    v    = (a[31] == b_eff[31]) && (y[31] != a[31]);
  end

endmodule

// File: rtl/alu_dword_sequencer.sv
// Runs 64-bit ADD/SUB/CMP as two passes through the 32-bit ALU, low word first,
// chaining the carry into the high-word pass; latches result and NZCV on completion.
module alu_dword_sequencer
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] result,
  output logic        C,
  output logic        N,
  output logic        V,
  output logic        Z,
  output dw_state_e   dbg_state
);

  // Handshake: start is sampled on a rising edge only while busy=0 (IDLE or DONE);
  // an accepted op completes with a one-cycle done exactly three edges later, a
  // reserved op gives a one-cycle err on the next cycle, and start while busy is dropped.

  dw_state_e   state, state_nxt;
  logic [63:0] a_q, b_q;
  dw_op_e      op_q;
  logic [31:0] lo_q;
  logic        c_q;
  logic        accept, reject;

  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  logic        alu_cin, alu_c, alu_v;

  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    alu_a     = a_q[31:0];
    alu_b     = b_q[31:0];
    alu_op    = ALU_ADD;
    alu_cin   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done      = (state == ST_DONE);
        state_nxt = ST_IDLE;
        if (start) begin
          if (op == DW_RSV) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        busy      = 1'b1;
        alu_op    = (op_q == DW_ADD) ? ALU_ADD : ALU_SUB;
        state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        busy      = 1'b1;
        alu_a     = a_q[63:32];
        alu_b     = b_q[63:32];
        alu_op    = (op_q == DW_ADD) ? ALU_ADC : ALU_SBC;
        alu_cin   = c_q;
        state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= DW_ADD;
      lo_q   <= '0;
      c_q    <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      C      <= 1'b0;
      N      <= 1'b0;
      V      <= 1'b0;
      Z      <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= dw_op_e'(op);
      end
      if (state == ST_LOW) begin
        lo_q <= alu_y;
        c_q  <= alu_c;
      end
      // Flags and result only ever change on the HIGH->DONE edge; CMP leaves result alone.
      if (state == ST_HIGH) begin
        C <= alu_c;
        V <= alu_v;
        N <= alu_y[31];
        Z <= (lo_q == 32'd0) && (alu_y == 32'd0);
        if (op_q != DW_CMP) result <= {alu_y, lo_q};
      end
    end
  end

  alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .op   (alu_op),
    .cin  (alu_cin),
    .y    (alu_y),
    .cout (alu_c),
    .v    (alu_v)
  );

endmodule

// File: tb/tb_alu_dword_sequencer.sv
// Scoreboard bench for alu_dword_sequencer: a 64-bit arithmetic model predicts every done/err.
module tb_alu_dword_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        busy, done, err;
  logic [63:0] result;
  logic        C, N, V, Z;
  dw_state_e   dbg_state;

  alu_dword_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .C         (C),
    .N         (N),
    .V         (V),
    .Z         (Z),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        is_err;
    logic [63:0] res;
    logic [3:0]  nzcv;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_res  = '0;
  logic [3:0]  m_nzcv = '0;
  int vectors     = 0;
  int miscompares = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Reference model: plain 64-bit arithmetic on the whole operands.
  task automatic model_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    logic [64:0] s;
    logic [63:0] r;
    logic        c, v;
    exp_t        e;
    if (o == 2'b11) begin
      e = '{is_err: 1'b1, res: m_res, nzcv: m_nzcv, cyc: 32'(cyc + 1)};
    end else begin
      if (o == 2'b00) begin
        s = {1'b0, x} + {1'b0, y};
        r = s[63:0];
        c = s[64];
        v = (x[63] == y[63]) && (r[63] != x[63]);
      end else begin
        r = x - y;
        c = (x >= y);
        v = (x[63] != y[63]) && (r[63] != x[63]);
      end
      m_nzcv = {r[63], (r == 64'd0), c, v};
      if (o != 2'b10) m_res = r;
      e = '{is_err: 1'b0, res: m_res, nzcv: m_nzcv, cyc: 32'(cyc + 3)};
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge of the DONE cycle plus 'idle' cycles.
  task automatic do_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       input int idle);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    model_op(o, x, y);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = {$urandom, $urandom};
    b     = {$urandom, $urandom};
    if (o != 2'b11) check("busy_low", busy, 1);
    @(negedge clk);
    if (o != 2'b11) check("busy_high", busy, 1);
    @(negedge clk);
    check("busy_after", busy, 0);
    repeat (idle) @(negedge clk);
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h0000_0000_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (done || err)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: done=%b err=%b, expected no output", done, err);
      end else begin
        e = exp_q.pop_front();
        check("err", err, e.is_err);
        check("done", done, !e.is_err);
        check("latency_cycle", cyc, e.cyc);
        check("result", result, e.res);
        check("nzcv", {N, Z, C, V}, e.nzcv);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  ro;
    logic [63:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_result", result, 0);
    check("rst_nzcv", {N, Z, C, V}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(2'b00, 64'h0000_0000_FFFF_FFFF, 64'd1, 0);
    check("tp_add_result", result, 64'h0000_0001_0000_0000);
    check("tp_add_nzcv", {N, Z, C, V}, 4'b0000);
    @(negedge clk);
    do_op(2'b01, 64'h0000_0001_0000_0000, 64'd1, 0);
    check("tp_sub_result", result, 64'h0000_0000_FFFF_FFFF);
    check("tp_sub_nzcv", {N, Z, C, V}, 4'b0010);
    do_op(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
    check("tp_addov_nzcv", {N, Z, C, V}, 4'b1001);
    do_op(2'b01, 64'h8000_0000_0000_0000, 64'd1, 1);
    check("tp_subov_nzcv", {N, Z, C, V}, 4'b0011);
    do_op(2'b00, 64'd0, 64'd5, 0);
    do_op(2'b10, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0);
    check("tp_cmp_result", result, 64'd5);
    check("tp_cmp_zc", {Z, C}, 2'b11);
    do_op(2'b11, 64'd7, 64'd9, 1);
    check("err_keeps_result", result, 64'd5);

    // start held high while busy must be ignored
    start = 1'b1; op = 2'b00; a = 64'd1; b = 64'd2;
    model_op(2'b00, 64'd1, 64'd2);
    @(posedge clk);
    @(negedge clk);
    op = 2'b01; a = 64'd99; b = 64'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("ignored_start_result", result, 64'd3);

    // Reset in the HIGH cycle
    start = 1'b1; op = 2'b00; a = 64'h1111_2222_3333_4444; b = 64'h5555;
    model_op(2'b00, a, b);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_state", dbg_state, ST_HIGH);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_nzcv", {N, Z, C, V}, 0);
    exp_q.delete();
    m_res  = '0;
    m_nzcv = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized traffic with mixed gaps, including back-to-back starts in DONE
    for (int i = 0; i < 150; i++) begin
      ro = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ra = rand64();
      rb = ($urandom_range(0, 7) == 0) ? ra : rand64();
      do_op(ro, ra, rb, $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
